// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, clog2 helper and writeback channel record
//
// Default sizes for the writeback stage and register file. The record type
// bundles one writeback channel: valid, is_load, dest, load data and ALU data.

package wb_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_WB_PORTS = 2;

  // Index width for n entries. Never returns less than 1 so that a
  // single-entry structure still gets a usable index.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  localparam int DEF_AW = clog2(DEF_NUM_REGS);

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic [DEF_AW-1:0]     dest;
    logic [DEF_DATA_W-1:0] ld;
    logic [DEF_DATA_W-1:0] alu;
  } wb_chan_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - writeback, issue and read-port bundle
//
// master: the core (writeback channels, issue request, read addresses)
// slave : the register file (issue ready, read data, busy flags, error)

import wb_pkg::*;

interface regfile_writeback_if #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int WB_PORTS = DEF_WB_PORTS,
  parameter int RD_PORTS = 4
);

  localparam int AW = clog2(NUM_REGS);

  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS-1:0]        wb_is_load;
  logic [WB_PORTS*AW-1:0]     wb_dest;
  logic [WB_PORTS*DATA_W-1:0] wb_ld_data;
  logic [WB_PORTS*DATA_W-1:0] wb_alu_data;
  logic                       iss_valid;
  logic [AW-1:0]              iss_dest;
  logic                       iss_ready;
  logic [RD_PORTS*AW-1:0]     rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       wb_error;

  modport master (
    output wb_valid, wb_is_load, wb_dest, wb_ld_data, wb_alu_data,
    output iss_valid, iss_dest, rd_addr,
    input  iss_ready, rd_data, rd_busy, wb_error
  );

  modport slave (
    input  wb_valid, wb_is_load, wb_dest, wb_ld_data, wb_alu_data,
    input  iss_valid, iss_dest, rd_addr,
    output iss_ready, rd_data, rd_busy, wb_error
  );

endinterface

// File: rtl/wb_merge.sv
// rtl/wb_merge.sv - per-register resolver of same-cycle writeback channels
//
// Inputs : wb_valid, wb_is_load, wb_dest, wb_ld_data, wb_alu_data (flat per channel)
// Outputs: hit      - some valid channel targets register r
//          win_data - result of the youngest (highest-index) channel hitting r
//          hit_cnt  - number of valid channels hitting r

import wb_pkg::*;

module wb_merge #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int WB_PORTS = DEF_WB_PORTS,
  parameter int AW       = clog2(NUM_REGS),
  parameter int HC_W     = clog2(WB_PORTS + 1)
) (
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS-1:0]        wb_is_load,
  input  logic [WB_PORTS*AW-1:0]     wb_dest,
  input  logic [WB_PORTS*DATA_W-1:0] wb_ld_data,
  input  logic [WB_PORTS*DATA_W-1:0] wb_alu_data,
  output logic [NUM_REGS-1:0]        hit,
  output logic [NUM_REGS*DATA_W-1:0] win_data,
  output logic [NUM_REGS*HC_W-1:0]   hit_cnt
);

  // Channels are scanned oldest to youngest so the last assignment to
  // win_data is the program-order winner.
  always_comb begin
    hit      = '0;
    win_data = '0;
    hit_cnt  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && (wb_dest[k*AW +: AW] == AW'(r))) begin
          hit[r] = 1'b1;
          win_data[r*DATA_W +: DATA_W] = wb_is_load[k] ? wb_ld_data[k*DATA_W +: DATA_W]
                                                       : wb_alu_data[k*DATA_W +: DATA_W];
          hit_cnt[r*HC_W +: HC_W] = hit_cnt[r*HC_W +: HC_W] + HC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - multi-port writeback stage, register file and pending scoreboard
//
// Ports: clk, rst (synchronous, active-high)
//        bus.slave - writeback channels, issue handshake (iss_valid/iss_dest/iss_ready),
//                    bypassed read ports (rd_addr/rd_data/rd_busy), sticky wb_error

import wb_pkg::*;

module regfile_writeback #(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter int                WB_PORTS  = DEF_WB_PORTS,
  parameter int                RD_PORTS  = 4,
  parameter int                CNT_W     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  regfile_writeback_if.slave bus
);

  localparam int AW   = clog2(NUM_REGS);
  localparam int HC_W = clog2(WB_PORTS + 1);
  // Wide enough for pend + issue without wrapping, and for any hit count.
  localparam int SW   = CNT_W + HC_W + 1;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [CNT_W-1:0]           pend_q [NUM_REGS];
  logic [CNT_W-1:0]           pend_d [NUM_REGS];
  logic                       wb_error_q;
  logic                       underflow;

  logic [WB_PORTS-1:0]        eff_valid;
  logic [NUM_REGS-1:0]        hit;
  logic [NUM_REGS*DATA_W-1:0] win_data;
  logic [NUM_REGS*HC_W-1:0]   hit_cnt;

  logic                       iss_ready_c;
  logic                       iss_fire;
  logic [RD_PORTS*DATA_W-1:0] rd_data_c;
  logic [RD_PORTS-1:0]        rd_busy_c;

  // Reset masks the channels so that nothing is written, counted or bypassed.
  assign eff_valid = bus.wb_valid & {WB_PORTS{~rst}};

  wb_merge #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .WB_PORTS (WB_PORTS),
    .AW       (AW),
    .HC_W     (HC_W)
  ) u_merge (
    .wb_valid    (eff_valid),
    .wb_is_load  (bus.wb_is_load),
    .wb_dest     (bus.wb_dest),
    .wb_ld_data  (bus.wb_ld_data),
    .wb_alu_data (bus.wb_alu_data),
    .hit         (hit),
    .win_data    (win_data),
    .hit_cnt     (hit_cnt)
  );

  // A saturated counter can still accept an issue when a writeback to the
  // same register frees a slot in the same cycle.
  always_comb begin
    iss_ready_c = 1'b1;
    if (!rst && (pend_q[bus.iss_dest] == PEND_MAX) && !hit[bus.iss_dest]) begin
      iss_ready_c = 1'b0;
    end
  end

  assign iss_fire      = bus.iss_valid & iss_ready_c & ~rst;
  assign bus.iss_ready = iss_ready_c;

  // Scoreboard next state. A completion with nothing outstanding clamps the
  // count at zero and flags the error; the data write still happens.
  always_comb begin
    logic [SW-1:0] sum;
    logic [SW-1:0] dec;
    underflow = 1'b0;
    sum       = '0;
    dec       = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sum = SW'(pend_q[r]) + SW'(iss_fire && (bus.iss_dest == AW'(r)));
      dec = SW'(hit_cnt[r*HC_W +: HC_W]);
      if (dec > sum) begin
        pend_d[r] = '0;
        underflow = 1'b1;
      end else begin
        pend_d[r] = CNT_W'(sum - dec);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= RESET_VAL;
        pend_q[r] <= '0;
      end
      wb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (hit[r]) begin
          regs_q[r] <= win_data[r*DATA_W +: DATA_W];
        end
        pend_q[r] <= pend_d[r];
      end
      wb_error_q <= wb_error_q | underflow;
    end
  end

  assign bus.wb_error = wb_error_q;

  // Read ports: bypass the winning writeback, otherwise the stored value.
  // Busy excludes this cycle's issue and saturates at "not busy" when more
  // completions arrive than are outstanding.
  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      a = bus.rd_addr[p*AW +: AW];
      if (rst) begin
        rd_data_c[p*DATA_W +: DATA_W] = RESET_VAL;
        rd_busy_c[p] = 1'b0;
      end else begin
        rd_data_c[p*DATA_W +: DATA_W] = hit[a] ? win_data[a*DATA_W +: DATA_W] : regs_q[a];
        rd_busy_c[p] = SW'(pend_q[a]) > SW'(hit_cnt[a*HC_W +: HC_W]);
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback

import wb_pkg::*;

module tb_regfile_writeback;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int WB_PORTS = 2;
  localparam int RD_PORTS = 4;
  localparam int CNT_W    = 2;
  localparam int AW       = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_writeback_if #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .WB_PORTS (WB_PORTS),
    .RD_PORTS (RD_PORTS)
  ) bus ();

  regfile_writeback #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .WB_PORTS  (WB_PORTS),
    .RD_PORTS  (RD_PORTS),
    .CNT_W     (CNT_W),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input int ch, input wb_chan_t c);
    bus.wb_valid[ch]                   = c.valid;
    bus.wb_is_load[ch]                 = c.is_load;
    bus.wb_dest[ch*AW +: AW]           = c.dest;
    bus.wb_ld_data[ch*DATA_W +: DATA_W]  = c.ld;
    bus.wb_alu_data[ch*DATA_W +: DATA_W] = c.alu;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    bus.wb_valid    = '0;
    bus.wb_is_load  = '0;
    bus.wb_dest     = '0;
    bus.wb_ld_data  = '0;
    bus.wb_alu_data = '0;
    bus.iss_valid   = 1'b0;
    bus.iss_dest    = '0;
  endtask

  task automatic issue(input logic [AW-1:0] d);
    bus.iss_valid = 1'b1;
    bus.iss_dest  = d;
    step();
    bus.iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    idle();
    bus.rd_addr = '0;
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_iss_ready_during act=%b exp=1", bus.iss_ready);
    end
    step();
    rst = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      set_rd(0, AW'(r));
      #1;
      d = bus.rd_data[0 +: DATA_W];
      checks++;
      if (d !== 16'h0000) begin
        errors++;
        $display("FAIL rst_data r%0d act=%h exp=0000", r, d);
      end
      checks++;
      if (bus.rd_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy r%0d act=%b exp=0", r, bus.rd_busy[0]);
      end
    end
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_iss_ready act=%b exp=1", bus.iss_ready);
    end
    checks++;
    if (bus.wb_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_wb_error act=%b exp=0", bus.wb_error);
    end
  endtask

  task automatic test_bypass();
    idle();
    set_rd(0, 3'd3);
    issue(3'd3);
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL byp_busy_pending act=%b exp=1", bus.rd_busy[0]);
    end
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd3, ld: 16'hDEAD, alu: 16'h1234});
    #1;
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h1234) begin
      errors++;
      $display("FAIL byp_data act=%h exp=1234", bus.rd_data[0 +: DATA_W]);
    end
    checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL byp_busy act=%b exp=0", bus.rd_busy[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h1234) begin
      errors++;
      $display("FAIL byp_stored act=%h exp=1234", bus.rd_data[0 +: DATA_W]);
    end
  endtask

  task automatic test_conflict();
    idle();
    set_rd(0, 3'd5);
    set_rd(1, 3'd5);
    issue(3'd5);
    issue(3'd5);
    drive_wb(0, '{valid: 1'b1, is_load: 1'b1, dest: 3'd5, ld: 16'hAAAA, alu: 16'h1111});
    drive_wb(1, '{valid: 1'b1, is_load: 1'b0, dest: 3'd5, ld: 16'h2222, alu: 16'h5555});
    #1;
    checks++;
    if (bus.rd_data[DATA_W +: DATA_W] !== 16'h5555) begin
      errors++;
      $display("FAIL cfl_bypass act=%h exp=5555", bus.rd_data[DATA_W +: DATA_W]);
    end
    checks++;
    if (bus.rd_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL cfl_busy_same act=%b exp=0", bus.rd_busy[1]);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h5555) begin
      errors++;
      $display("FAIL cfl_stored act=%h exp=5555", bus.rd_data[0 +: DATA_W]);
    end
    checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfl_pend_zero act=%b exp=0", bus.rd_busy[0]);
    end
    checks++;
    if (bus.wb_error !== 1'b0) begin
      errors++;
      $display("FAIL cfl_wb_error act=%b exp=0", bus.wb_error);
    end
  endtask

  task automatic test_multi_port();
    logic [DATA_W-1:0] exp [4];
    exp = '{16'h0F0F, 16'h7777, 16'h1234, 16'h5555};
    idle();
    issue(3'd4);
    issue(3'd7);
    set_rd(0, 3'd4);
    set_rd(1, 3'd7);
    set_rd(2, 3'd3);
    set_rd(3, 3'd5);
    drive_wb(0, '{valid: 1'b1, is_load: 1'b1, dest: 3'd4, ld: 16'h0F0F, alu: 16'hFFFF});
    drive_wb(1, '{valid: 1'b1, is_load: 1'b0, dest: 3'd7, ld: 16'hEEEE, alu: 16'h7777});
    step();
    idle();
    #1;
    for (int p = 0; p < RD_PORTS; p++) begin
      checks++;
      if (bus.rd_data[p*DATA_W +: DATA_W] !== exp[p]) begin
        errors++;
        $display("FAIL mp_read p%0d act=%h exp=%h", p, bus.rd_data[p*DATA_W +: DATA_W], exp[p]);
      end
    end
  endtask

  task automatic test_saturate();
    idle();
    set_rd(2, 3'd2);
    bus.iss_valid = 1'b1;
    bus.iss_dest  = 3'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.iss_ready !== 1'b1) begin
        errors++;
        $display("FAIL sat_accept%0d act=%b exp=1", i, bus.iss_ready);
      end
      step();
    end
    #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_full act=%b exp=0", bus.iss_ready);
    end
    checks++;
    if (bus.rd_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_busy act=%b exp=1", bus.rd_busy[2]);
    end
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd2, ld: 16'h0000, alu: 16'h2A2A});
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_free_slot act=%b exp=1", bus.iss_ready);
    end
    step();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_dest  = 3'd2;
    #1;
    checks++;
    if (bus.iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_still_full act=%b exp=0", bus.iss_ready);
    end
    bus.iss_valid = 1'b0;
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd2, ld: 16'h0000, alu: 16'h0202});
    drive_wb(1, '{valid: 1'b1, is_load: 1'b1, dest: 3'd2, ld: 16'h2020, alu: 16'h0000});
    #1;
    checks++;
    if (bus.rd_data[2*DATA_W +: DATA_W] !== 16'h2020) begin
      errors++;
      $display("FAIL sat_drain_bypass act=%h exp=2020", bus.rd_data[2*DATA_W +: DATA_W]);
    end
    step();
    idle();
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd2, ld: 16'h0000, alu: 16'h0303});
    step();
    idle();
    #1;
    checks++;
    if (bus.rd_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL sat_drained act=%b exp=0", bus.rd_busy[2]);
    end
    checks++;
    if (bus.rd_data[2*DATA_W +: DATA_W] !== 16'h0303) begin
      errors++;
      $display("FAIL sat_final_data act=%h exp=0303", bus.rd_data[2*DATA_W +: DATA_W]);
    end
    checks++;
    if (bus.wb_error !== 1'b0) begin
      errors++;
      $display("FAIL sat_wb_error act=%b exp=0", bus.wb_error);
    end
  endtask

  task automatic test_error();
    idle();
    set_rd(0, 3'd6);
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd6, ld: 16'h0000, alu: 16'h6666});
    #1;
    checks++;
    if (bus.wb_error !== 1'b0) begin
      errors++;
      $display("FAIL err_before_edge act=%b exp=0", bus.wb_error);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.wb_error !== 1'b1) begin
      errors++;
      $display("FAIL err_set act=%b exp=1", bus.wb_error);
    end
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h6666) begin
      errors++;
      $display("FAIL err_write_done act=%h exp=6666", bus.rd_data[0 +: DATA_W]);
    end
    step();
    step();
    step();
    checks++;
    if (bus.wb_error !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky act=%b exp=1", bus.wb_error);
    end
  endtask

  task automatic test_reset_override();
    idle();
    set_rd(0, 3'd1);
    issue(3'd1);
    bus.iss_valid = 1'b1;
    bus.iss_dest  = 3'd1;
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd1, ld: 16'h0000, alu: 16'h1111});
    step();
    idle();
    #1;
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h1111 || bus.rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_setup act=%h/%b exp=1111/1", bus.rd_data[0 +: DATA_W], bus.rd_busy[0]);
    end
    rst = 1'b1;
    bus.iss_valid = 1'b1;
    bus.iss_dest  = 3'd1;
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd1, ld: 16'h0000, alu: 16'hBEEF});
    #1;
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h0000) begin
      errors++;
      $display("FAIL ovr_no_bypass act=%h exp=0000", bus.rd_data[0 +: DATA_W]);
    end
    checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovr_during act=busy%b/rdy%b exp=busy0/rdy1", bus.rd_busy[0], bus.iss_ready);
    end
    step();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== 16'h0000) begin
      errors++;
      $display("FAIL ovr_r1_reset act=%h exp=0000", bus.rd_data[0 +: DATA_W]);
    end
    checks++;
    if (bus.rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pend_cleared act=%b exp=0", bus.rd_busy[0]);
    end
    checks++;
    if (bus.wb_error !== 1'b0) begin
      errors++;
      $display("FAIL ovr_err_cleared act=%b exp=0", bus.wb_error);
    end
    drive_wb(0, '{valid: 1'b1, is_load: 1'b0, dest: 3'd1, ld: 16'h0000, alu: 16'h2222});
    step();
    idle();
    #1;
    checks++;
    if (bus.wb_error !== 1'b1) begin
      errors++;
      $display("FAIL ovr_stale_wb_error act=%b exp=1", bus.wb_error);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    bus.rd_addr = '0;
    test_reset();
    test_bypass();
    test_conflict();
    test_multi_port();
    test_saturate();
    test_error();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
